sp_issue: RTL and testbench
===========================

# sp_issue

Instruction fetch/decode/issue sequencer sitting directly upstream of `spcore`. It fetches 40-bit instruction words from instruction memory over a req/valid handshake and decodes them into the core control fields `x`, `y`, `z`, `I`, `aluc`, `s2`, `reg_we` and `en`. It handles jump, predicated branch on the core's `P` output, and halt. All SP cores are driven in lockstep from this single issue stage.

## Interface
Parameters:
- `ADDR_W`, 16, PC and instruction-memory address width.
- `BR_LAT`, 2, cycles waited after BRP decode before sampling `core_p` (range 1..15).

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  pulse; begins execution at `start_pc` when idle or halted.
- `start_pc`  in  ADDR_W  initial PC.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDR_W  fetch address (= pc).
- `imem_valid`  in  1  fetch data valid.
- `imem_data`  in  40  instruction word.
- `core_p`  in  1  predicate from `spcore` `P`.
- `x`, `y`, `z`  out  4 each  register indices.
- `I`  out  16  immediate.
- `aluc`  out  4  ALU control.
- `s2`  out  2  operand mux select.
- `reg_we`  out  1  register write enable.
- `en`  out  1  core enable, one cycle per issued ALU instruction.
- `busy`  out  1  high in every state except IDLE and HALT.
- `done`  out  1  high in HALT.
- `err`  out  1  illegal opcode seen.
- `pc`  out  ADDR_W  current PC.

## Operation
- Instruction word fields: [39:36] op, [35:32] aluc, [31:30] s2, [29:28] reserved (ignored), [27:24] x, [23:20] y, [19:16] z, [15:0] I.
- Opcodes:
  - 0 NOP: pc+1.
  - 1 ALU: issue with reg_we=1.
  - 2 ALUN: issue with reg_we=0.
  - 3 JMP: pc=I[ADDR_W-1:0].
  - 4 BRP: conditional branch on `core_p`.
  - 5 HALT.
  - 6..15 illegal: set err, enter HALT.
- FSM states: IDLE, FETCH, ISSUE, WAITP, HALT.
  - IDLE or HALT with start=1: pc<=start_pc, err<=0, go to FETCH.
  - In IDLE, BUSY states and HALT, start is ignored except as above.
- FETCH:
  - imem_req=1, imem_addr=pc; both held stable until imem_valid.
  - On an edge with imem_req & imem_valid, decode imem_data.
  - ALU/ALUN: register fields and go to ISSUE.
  - NOP: pc+1, stay in FETCH.
  - JMP: pc=I, stay in FETCH.
  - BRP: load counter with BR_LAT, latch target, go to WAITP.
  - HALT/illegal: go to HALT.
- ISSUE: en=1 for exactly one cycle; pc+1; go to FETCH.
- WAITP:
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, sample core_p: pc = target if 1, else pc+1; go to FETCH.
- pc increments wrap from 2^ADDR_W-1 to 0.
- imem_valid is ignored when imem_req=0.
- Field outputs hold their last issued value between issues. reg_we is forced 0 whenever en=0.

## Timing
- Reset (reset=0 at an edge), applied from any state including mid-fetch or WAITP:
  - State IDLE; pc=0.
  - x, y, z, I, aluc, s2 all 0.
  - reg_we=0, en=0, imem_req=0, busy=0, done=0, err=0.
- Start: start sampled at edge N, imem_req=1 during cycle N+1.
- Zero-wait memory (imem_valid combinational with imem_req):
  - ALU/ALUN: 2 cycles per instruction; en high in the cycle after capture.
  - NOP/JMP: 1 cycle.
  - BRP: 1+BR_LAT cycles.
- Each wait cycle on imem_valid extends FETCH by one cycle. No fetch is issued during ISSUE or WAITP.
- done rises in the cycle after the HALT word is captured.

## Configuration
- `SP_ISSUE_ICOUNT_EN` defined:
  - Adds output `icount` (32 bits), counting ISSUE cycles (en=1).
  - Cleared by reset and by an accepted start; saturates at 2^32-1.
- Not defined: port and counter are absent. All other behaviour is identical.

## Structure
- Package `sp_issue_pkg` holds:
  - Opcode constants OP_NOP..OP_HALT.
  - Field bit-position constants.
  - FSM state encoding.
  - INSTR_W=40.
- Sub-module `sp_issue_decode`: combinational word-to-fields/op-class decoder. The FSM, PC and counters stay in `sp_issue`.

## Test plan
- Reset/start: reset low 2 cycles, then start with start_pc=0x0010 → all outputs at reset values; imem_req=1 with imem_addr=0x0010 one cycle after start.
- ALU issue: word op=1, aluc=7, s2=0, x=1, y=2, z=3, I=0x00A3 → one cycle en=1, reg_we=1 with those fields; pc goes 0x10→0x11; next fetch 2 cycles after the previous one.
- Memory stall: imem_valid delayed 3 cycles → imem_addr held stable and en stays 0 during the stall; issue follows the capture.
- Branch: BRP with I=0x0040, BR_LAT=2:
  - core_p=1 on the sample cycle → next imem_addr=0x0040.
  - core_p=0 → next imem_addr=pc+1.
- Halt/illegal/wrap:
  - op=5 → done=1, busy=0.
  - op=9 → err=1, done=1.
  - NOP at pc=0xFFFF → next fetch at 0x0000.
  - Reset asserted during WAITP → IDLE with all outputs at reset values.

Source files
------------

// File: rtl/sp_issue_pkg.sv
// sp_issue_pkg: shared definitions for the sp_issue fetch/decode/issue stage.
//   - instruction width and field bit positions of the 40-bit instruction word
//   - opcode constants OP_NOP..OP_HALT
//   - FSM state encoding and decoded op-class encoding
//   - packed struct carrying the core control fields of one instruction
package sp_issue_pkg;

    localparam int unsigned INSTR_W = 40;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ALU  = 4'd1;
    localparam logic [3:0] OP_ALUN = 4'd2;
    localparam logic [3:0] OP_JMP  = 4'd3;
    localparam logic [3:0] OP_BRP  = 4'd4;
    localparam logic [3:0] OP_HALT = 4'd5;

    localparam int unsigned OP_HI   = 39;
    localparam int unsigned OP_LO   = 36;
    localparam int unsigned ALUC_HI = 35;
    localparam int unsigned ALUC_LO = 32;
    localparam int unsigned S2_HI   = 31;
    localparam int unsigned S2_LO   = 30;
    localparam int unsigned RSV_HI  = 29;
    localparam int unsigned RSV_LO  = 28;
    localparam int unsigned X_HI    = 27;
    localparam int unsigned X_LO    = 24;
    localparam int unsigned Y_HI    = 23;
    localparam int unsigned Y_LO    = 20;
    localparam int unsigned Z_HI    = 19;
    localparam int unsigned Z_LO    = 16;
    localparam int unsigned I_HI    = 15;
    localparam int unsigned I_LO    = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAITP,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_ALUN,
        CLS_JMP,
        CLS_BRP,
        CLS_HALT,
        CLS_ILL
    } op_class_t;

    typedef struct packed {
        logic [3:0]  aluc;
        logic [1:0]  s2;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [3:0]  z;
        logic [15:0] imm;
    } fields_t;

endpackage

// File: rtl/sp_issue_decode.sv
// sp_issue_decode: purely combinational instruction-word decoder.
// Ports:
//   word     in  INSTR_W  raw instruction word from instruction memory
//   op_class out          decoded operation class (opcodes 6..15 -> CLS_ILL)
//   fields   out          aluc/s2/x/y/z/imm fields; reserved bits [29:28] ignored
module sp_issue_decode
    import sp_issue_pkg::*;
(
    input  logic [INSTR_W-1:0] word,
    output op_class_t          op_class,
    output fields_t            fields
);

    logic [3:0]               op;
    logic [RSV_HI-RSV_LO:0]   unused_rsvd;

    assign op          = word[OP_HI:OP_LO];
    assign unused_rsvd = word[RSV_HI:RSV_LO];

    always_comb begin
        fields.aluc = word[ALUC_HI:ALUC_LO];
        fields.s2   = word[S2_HI:S2_LO];
        fields.x    = word[X_HI:X_LO];
        fields.y    = word[Y_HI:Y_LO];
        fields.z    = word[Z_HI:Z_LO];
        fields.imm  = word[I_HI:I_LO];

        op_class = CLS_ILL;
        case (op)
            OP_NOP:  op_class = CLS_NOP;
            OP_ALU:  op_class = CLS_ALU;
            OP_ALUN: op_class = CLS_ALUN;
            OP_JMP:  op_class = CLS_JMP;
            OP_BRP:  op_class = CLS_BRP;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/sp_issue.sv
// sp_issue: instruction fetch/decode/issue sequencer driving the SP cores in lockstep.
// Fetches 40-bit words over a req/valid handshake, issues ALU/ALUN instructions as a
// one-cycle en pulse with the decoded control fields, and handles NOP, JMP, predicated
// branch (BRP, sampling core_p BR_LAT cycles after decode) and HALT/illegal.
// Ports:
//   clk, reset (sync, active-low), start/start_pc     control
//   imem_req/imem_addr out, imem_valid/imem_data in   instruction fetch
//   core_p in                                         branch predicate from spcore P
//   x/y/z/I/aluc/s2/reg_we/en out                     core control fields
//   busy/done/err/pc out                              status
//   icount out (32b)                                  issue counter, only when
//                                                     SP_ISSUE_ICOUNT_EN is defined
module sp_issue
    import sp_issue_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned BR_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               core_p,
    output logic [3:0]         x,
    output logic [3:0]         y,
    output logic [3:0]         z,
    output logic [15:0]        I,
    output logic [3:0]         aluc,
    output logic [1:0]         s2,
    output logic               reg_we,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W-1:0]  pc
`ifdef SP_ISSUE_ICOUNT_EN
    ,
    output logic [31:0]        icount
`endif
);

    localparam logic [3:0] BR_LAT_C = 4'(BR_LAT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d, pc_inc, dec_tgt;
    logic [3:0]        cnt_q, cnt_d;
    fields_t           fld_q, dec_fld;
    op_class_t         dec_cls;
    logic              we_q, fld_ld, err_q, err_d;

    sp_issue_decode u_decode (
        .word     (imem_data),
        .op_class (dec_cls),
        .fields   (dec_fld)
    );

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign dec_tgt = ADDR_W'(dec_fld.imm);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fld_ld   = 1'b0;

        imem_req = (state_q == ST_FETCH);
        en       = (state_q == ST_ISSUE);
        busy     = (state_q == ST_FETCH) || (state_q == ST_ISSUE) || (state_q == ST_WAITP);
        done     = (state_q == ST_HALT);
        reg_we   = (state_q == ST_ISSUE) && we_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = start_pc;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    case (dec_cls)
                        CLS_ALU, CLS_ALUN: begin
                            fld_ld  = 1'b1;
                            state_d = ST_ISSUE;
                        end
                        CLS_NOP:  pc_d = pc_inc;
                        CLS_JMP:  pc_d = dec_tgt;
                        CLS_BRP: begin
                            cnt_d   = BR_LAT_C;
                            tgt_d   = dec_tgt;
                            state_d = ST_WAITP;
                        end
                        CLS_HALT: state_d = ST_HALT;
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                pc_d    = pc_inc;
                state_d = ST_FETCH;
            end
            ST_WAITP: begin
                // core_p is sampled in the last WAITP cycle, BR_LAT cycles after decode
                if (cnt_q == 4'd1) begin
                    pc_d    = core_p ? tgt_q : pc_inc;
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            fld_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (fld_ld) begin
                fld_q <= dec_fld;
                we_q  <= (dec_cls == CLS_ALU);
            end
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign err       = err_q;
    assign x         = fld_q.x;
    assign y         = fld_q.y;
    assign z         = fld_q.z;
    assign I         = fld_q.imm;
    assign aluc      = fld_q.aluc;
    assign s2        = fld_q.s2;

`ifdef SP_ISSUE_ICOUNT_EN
    logic [31:0] icount_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            icount_q <= '0;
        end else if (((state_q == ST_IDLE) || (state_q == ST_HALT)) && start) begin
            icount_q <= '0;
        end else if ((state_q == ST_ISSUE) && (icount_q != '1)) begin
            icount_q <= icount_q + 32'd1;
        end
    end

    assign icount = icount_q;
`endif

endmodule

// File: tb/tb_sp_issue.sv
// tb_sp_issue: self-checking bench for sp_issue (default build, BR_LAT=2).
// An instruction-level interpreter predicts fetch addresses, fetch timing, issued
// fields and halt/err outcome; a negedge monitor records what the DUT actually did.
module tb_sp_issue;

    localparam int BR_LAT = 2;
    localparam logic [39:0] JUNK = {4'd1, 36'hF_FFFF_FFFF};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_pc = 16'h0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [39:0] imem_data;
    logic        core_p;
    logic [3:0]  x, y, z, aluc;
    logic [15:0] I;
    logic [1:0]  s2;
    logic        reg_we, en, busy, done, err;
    logic [15:0] pc;

    sp_issue #(.ADDR_W(16), .BR_LAT(BR_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_data(imem_data), .core_p(core_p),
        .x(x), .y(y), .z(z), .I(I), .aluc(aluc), .s2(s2),
        .reg_we(reg_we), .en(en), .busy(busy), .done(done), .err(err), .pc(pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  x, y, z, aluc;
        logic [15:0] imm;
        logic [1:0]  s2;
        logic        we;
        int          cyc;
    } iss_t;

    int checks = 0;
    int failures = 0;

    logic [39:0] mem [0:65535];
    int unsigned stall_arr [0:255];
    logic        br_dec [0:255];

    int          cyc = 0;
    int          start_cyc = 0;
    int unsigned wait_left = 0, fidx = 0, br_idx = 0, br_age = 0;
    logic        cur_dec = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: valid may be high even with no request; data is junk unless a real fetch.
    assign imem_valid = (wait_left == 0);
    assign imem_data  = (imem_req && imem_valid) ? mem[imem_addr] : JUNK;
    // Predicate is the chosen decision only on the sample cycle, its complement elsewhere.
    assign core_p     = (br_age == BR_LAT) ? cur_dec : ~cur_dec;

    always @(posedge clk) begin
        if (start) begin
            fidx      <= 0;
            wait_left <= stall_arr[0];
            br_idx    <= 0;
            br_age    <= 0;
        end else if (imem_req && imem_valid) begin
            fidx      <= fidx + 1;
            wait_left <= stall_arr[(fidx + 1) % 256];
            if (imem_data[39:36] == 4'd4) begin
                br_age  <= 1;
                cur_dec <= br_dec[br_idx % 256];
                br_idx  <= br_idx + 1;
            end else if (br_age != 0 && br_age < 100) begin
                br_age <= br_age + 1;
            end
        end else begin
            if (imem_req && wait_left != 0) wait_left <= wait_left - 1;
            if (br_age != 0 && br_age < 100) br_age <= br_age + 1;
        end
    end

    // Monitor (append-only)
    logic [15:0] got_addr[$];
    int          got_acyc[$];
    iss_t        got_iss[$];
    int          done_rise[$];
    int          stall_viol = 0, we_viol = 0;
    logic        prev_stall = 1'b0, prev_done = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    iss_t        mon_e;

    always @(negedge clk) begin
        if (imem_req && imem_valid) begin
            got_addr.push_back(imem_addr);
            got_acyc.push_back(cyc);
        end
        if (en === 1'b1) begin
            mon_e.x = x; mon_e.y = y; mon_e.z = z; mon_e.aluc = aluc;
            mon_e.imm = I; mon_e.s2 = s2; mon_e.we = reg_we; mon_e.cyc = cyc;
            got_iss.push_back(mon_e);
        end
        if (en === 1'b0 && reg_we === 1'b1) we_viol = we_viol + 1;
        if (prev_stall && imem_addr !== prev_addr) stall_viol = stall_viol + 1;
        prev_stall = (imem_req === 1'b1) && !imem_valid;
        prev_addr  = imem_addr;
        if (done === 1'b1 && !prev_done) done_rise.push_back(cyc);
        prev_done = (done === 1'b1);
    end

    // Reference model
    logic [15:0] exp_addr[$];
    int          exp_acyc[$];
    iss_t        exp_iss[$];
    int          exp_done_cyc;
    logic        exp_err;
    int          a0, i0, d0, sv0, wv0;

    task automatic build_expected(input logic [15:0] spc);
        logic [15:0] p;
        logic [39:0] w;
        int t, k, b, cost;
        bit stop;
        iss_t e;
        exp_addr.delete(); exp_acyc.delete(); exp_iss.delete();
        p = spc; t = 1 + int'(stall_arr[0]); k = 0; b = 0; stop = 0;
        exp_err = 1'b0; exp_done_cyc = -1;
        for (int n = 0; n < 1000 && !stop; n++) begin
            w = mem[p];
            exp_addr.push_back(p);
            exp_acyc.push_back(t);
            cost = 1;
            case (w[39:36])
                4'd0: p = p + 16'd1;
                4'd1, 4'd2: begin
                    e.aluc = w[35:32]; e.s2 = w[31:30]; e.x = w[27:24]; e.y = w[23:20];
                    e.z = w[19:16]; e.imm = w[15:0]; e.we = (w[39:36] == 4'd1); e.cyc = t + 1;
                    exp_iss.push_back(e);
                    p = p + 16'd1;
                    cost = 2;
                end
                4'd3: p = w[15:0];
                4'd4: begin
                    p = br_dec[b % 256] ? w[15:0] : p + 16'd1;
                    b++;
                    cost = 1 + BR_LAT;
                end
                4'd5: begin stop = 1; exp_done_cyc = t + 1; end
                default: begin stop = 1; exp_err = 1'b1; exp_done_cyc = t + 1; end
            endcase
            k++;
            t = t + cost + int'(stall_arr[k % 256]);
        end
    endtask

    function automatic logic [39:0] mk(input logic [3:0] op, input logic [3:0] ac,
                                       input logic [1:0] sel, input logic [1:0] rsv,
                                       input logic [3:0] rx, input logic [3:0] ry,
                                       input logic [3:0] rz, input logic [15:0] imm);
        return {op, ac, sel, rsv, rx, ry, rz, imm};
    endfunction

    task automatic set_stalls(input int unsigned maxw);
        for (int i = 0; i < 256; i++) begin
            stall_arr[i] = $urandom_range(maxw, 0);
            br_dec[i]    = 1'($urandom);
        end
    endtask

    task automatic run_prog(input logic [15:0] spc, output bit timeout);
        @(negedge clk);
        a0 = got_addr.size(); i0 = got_iss.size(); d0 = done_rise.size();
        sv0 = stall_viol; wv0 = we_viol;
        start_pc = spc; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        timeout = 1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin timeout = 0; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit to;
        reset = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({x, y, z, I, aluc, s2} !== 34'h0) begin
            failures++; $display("FAIL reset_fields got=%h exp=0", {x, y, z, I, aluc, s2});
        end
        checks++;
        if ({reg_we, en, imem_req, busy, done, err} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000", {reg_we, en, imem_req, busy, done, err});
        end
        checks++;
        if (pc !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        reset = 1'b1;
        set_stalls(0);
        mem[16'h0010] = mk(4'd1, 4'd7, 2'd0, 2'd3, 4'd1, 4'd2, 4'd3, 16'h00A3);
        mem[16'h0011] = mk(4'd5, 4'd0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 16'h0);
        @(negedge clk);
        start_pc = 16'h0010; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
            failures++; $display("FAIL start_fetch got req=%b addr=%h exp req=1 addr=0010", imem_req, imem_addr);
        end
        to = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin to = 0; break; end
        end
        checks++;
        if (to) begin failures++; $display("FAIL reset_run_timeout got=timeout exp=done"); end
    endtask

    task automatic test_alu();
        bit to;
        set_stalls(0);
        run_prog(16'h0010, to);
        checks++;
        if (to) begin failures++; $display("FAIL alu_timeout got=timeout exp=done"); end
        checks++;
        if (got_iss.size() - i0 !== 1) begin
            failures++; $display("FAIL alu_issue_count got=%0d exp=1", got_iss.size() - i0);
        end else begin
            checks++;
            if ({got_iss[i0].x, got_iss[i0].y, got_iss[i0].z, got_iss[i0].aluc, got_iss[i0].s2,
                 got_iss[i0].imm, got_iss[i0].we} !== {4'd1, 4'd2, 4'd3, 4'd7, 2'd0, 16'h00A3, 1'b1}) begin
                failures++;
                $display("FAIL alu_fields got x=%h y=%h z=%h aluc=%h s2=%h I=%h we=%b exp x=1 y=2 z=3 aluc=7 s2=0 I=00a3 we=1",
                         got_iss[i0].x, got_iss[i0].y, got_iss[i0].z, got_iss[i0].aluc,
                         got_iss[i0].s2, got_iss[i0].imm, got_iss[i0].we);
            end
            checks++;
            if (got_iss[i0].cyc - start_cyc !== 2) begin
                failures++; $display("FAIL alu_en_cycle got=%0d exp=2", got_iss[i0].cyc - start_cyc);
            end
        end
        checks++;
        if (got_addr.size() - a0 !== 2) begin
            failures++; $display("FAIL alu_fetch_count got=%0d exp=2", got_addr.size() - a0);
        end else begin
            checks++;
            if (got_addr[a0 + 1] !== 16'h0011) begin
                failures++; $display("FAIL alu_next_pc got=%h exp=0011", got_addr[a0 + 1]);
            end
            checks++;
            if (got_acyc[a0 + 1] - got_acyc[a0] !== 2) begin
                failures++; $display("FAIL alu_fetch_gap got=%0d exp=2", got_acyc[a0 + 1] - got_acyc[a0]);
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        set_stalls(0);
        stall_arr[0] = 3;
        run_prog(16'h0010, to);
        checks++;
        if (to) begin failures++; $display("FAIL stall_timeout got=timeout exp=done"); end
        checks++;
        if (got_addr.size() - a0 < 1 || got_acyc[a0] - start_cyc !== 4) begin
            failures++; $display("FAIL stall_capture_cycle got=%0d exp=4",
                                 (got_addr.size() > a0) ? got_acyc[a0] - start_cyc : -1);
        end
        checks++;
        if (got_iss.size() - i0 !== 1 || got_iss[i0].cyc - start_cyc !== 5) begin
            failures++; $display("FAIL stall_issue got count=%0d exp count=1 cycle=5", got_iss.size() - i0);
        end
        checks++;
        if (stall_viol - sv0 !== 0) begin
            failures++; $display("FAIL stall_addr_stable got=%0d changes exp=0", stall_viol - sv0);
        end
    endtask

    task automatic test_branch();
        bit to;
        logic [15:0] want;
        mem[16'h0020] = mk(4'd4, 4'd0, 2'd0, 2'd2, 4'd0, 4'd0, 4'd0, 16'h0040);
        mem[16'h0021] = mk(4'd5, 4'd0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 16'h0);
        mem[16'h0040] = mk(4'd5, 4'd0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 16'h0);
        for (int d = 1; d >= 0; d--) begin
            set_stalls(0);
            br_dec[0] = 1'(d);
            want = (d == 1) ? 16'h0040 : 16'h0021;
            run_prog(16'h0020, to);
            checks++;
            if (to || got_addr.size() - a0 !== 2) begin
                failures++; $display("FAIL branch_p%0d_fetches got=%0d exp=2", d, got_addr.size() - a0);
            end else begin
                checks++;
                if (got_addr[a0 + 1] !== want) begin
                    failures++; $display("FAIL branch_p%0d_target got=%h exp=%h", d, got_addr[a0 + 1], want);
                end
                checks++;
                if (got_acyc[a0 + 1] - got_acyc[a0] !== 1 + BR_LAT) begin
                    failures++; $display("FAIL branch_p%0d_latency got=%0d exp=%0d", d,
                                         got_acyc[a0 + 1] - got_acyc[a0], 1 + BR_LAT);
                end
            end
        end
    endtask

    task automatic test_halt_illegal();
        bit to;
        set_stalls(0);
        mem[16'h0050] = mk(4'd5, 4'd0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 16'h0);
        mem[16'h0060] = mk(4'd9, 4'd3, 2'd1, 2'd0, 4'd5, 4'd6, 4'd7, 16'h1234);
        run_prog(16'h0050, to);
        checks++;
        if (to || {done, busy, err} !== 3'b100) begin
            failures++; $display("FAIL halt_status got done=%b busy=%b err=%b exp done=1 busy=0 err=0", done, busy, err);
        end
        checks++;
        if (done_rise.size() - d0 !== 1 || done_rise[d0] - start_cyc !== 2) begin
            failures++; $display("FAIL halt_done_cycle got rises=%0d exp rises=1 at cycle 2", done_rise.size() - d0);
        end
        run_prog(16'h0060, to);
        checks++;
        if (to || {done, busy, err} !== 3'b101) begin
            failures++; $display("FAIL illegal_status got done=%b busy=%b err=%b exp done=1 busy=0 err=1", done, busy, err);
        end
        checks++;
        if (got_iss.size() - i0 !== 0) begin
            failures++; $display("FAIL illegal_no_issue got=%0d exp=0", got_iss.size() - i0);
        end
    endtask

    task automatic test_wrap();
        bit to;
        set_stalls(0);
        mem[16'hFFFF] = mk(4'd0, 4'd0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 16'h0);
        mem[16'h0000] = mk(4'd5, 4'd0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 16'h0);
        run_prog(16'hFFFF, to);
        checks++;
        if (to || got_addr.size() - a0 !== 2 || got_addr[a0 + 1] !== 16'h0000) begin
            failures++; $display("FAIL wrap_next_fetch got count=%0d exp count=2 addr=0000", got_addr.size() - a0);
        end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL wrap_err_cleared got=%b exp=0", err); end
    endtask

    task automatic test_reset_waitp();
        set_stalls(0);
        mem[16'h0030] = mk(4'd4, 4'd0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 16'h0040);
        @(negedge clk);
        start_pc = 16'h0030; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || imem_req !== 1'b0) begin
            failures++; $display("FAIL waitp_entered got busy=%b req=%b exp busy=1 req=0", busy, imem_req);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if ({x, y, z, I, aluc, s2} !== 34'h0 || pc !== 16'h0) begin
            failures++; $display("FAIL waitp_reset_fields got=%h pc=%h exp=0 pc=0000", {x, y, z, I, aluc, s2}, pc);
        end
        checks++;
        if ({reg_we, en, imem_req, busy, done, err} !== 6'b0) begin
            failures++; $display("FAIL waitp_reset_ctrl got=%b exp=000000", {reg_we, en, imem_req, busy, done, err});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({imem_req, busy, pc} !== 18'h0) begin
            failures++; $display("FAIL waitp_stays_idle got req=%b busy=%b pc=%h exp 0 0 0000", imem_req, busy, pc);
        end
    endtask

    task automatic test_random();
        bit to;
        int unsigned base, len, r, op;
        int nf, ni;
        for (int it = 0; it < 10; it++) begin
            base = $urandom_range(16'hE000, 16'h1000);
            len  = $urandom_range(24, 8);
            for (int unsigned k = 0; k < len - 1; k++) begin
                r = $urandom_range(99, 0);
                if (r < 15)      op = 0;
                else if (r < 45) op = 1;
                else if (r < 60) op = 2;
                else if (r < 72) op = 3;
                else if (r < 88) op = 4;
                else if (r >= 97 && k > len / 2) op = $urandom_range(15, 6);
                else             op = 1;
                mem[16'(base + k)] = mk(4'(op), 4'($urandom), 2'($urandom), 2'($urandom),
                                        4'($urandom), 4'($urandom), 4'($urandom),
                                        (op == 3 || op == 4) ? 16'(base + $urandom_range(len - 1, k + 1))
                                                             : 16'($urandom));
            end
            mem[16'(base + len - 1)] = mk(4'd5, 4'd0, 2'd0, 2'($urandom), 4'd0, 4'd0, 4'd0, 16'($urandom));
            set_stalls(2);
            build_expected(16'(base));
            run_prog(16'(base), to);
            checks++;
            if (to) begin failures++; $display("FAIL rnd%0d_timeout got=timeout exp=done", it); end
            nf = got_addr.size() - a0;
            ni = got_iss.size() - i0;
            checks++;
            if (nf !== exp_addr.size()) begin
                failures++; $display("FAIL rnd%0d_fetch_count got=%0d exp=%0d", it, nf, exp_addr.size());
            end
            for (int j = 0; j < nf && j < exp_addr.size(); j++) begin
                checks++;
                if (got_addr[a0 + j] !== exp_addr[j] || got_acyc[a0 + j] - start_cyc !== exp_acyc[j]) begin
                    failures++;
                    $display("FAIL rnd%0d_fetch%0d got addr=%h cyc=%0d exp addr=%h cyc=%0d", it, j,
                             got_addr[a0 + j], got_acyc[a0 + j] - start_cyc, exp_addr[j], exp_acyc[j]);
                end
            end
            checks++;
            if (ni !== exp_iss.size()) begin
                failures++; $display("FAIL rnd%0d_issue_count got=%0d exp=%0d", it, ni, exp_iss.size());
            end
            for (int j = 0; j < ni && j < exp_iss.size(); j++) begin
                checks++;
                if ({got_iss[i0 + j].x, got_iss[i0 + j].y, got_iss[i0 + j].z, got_iss[i0 + j].aluc,
                     got_iss[i0 + j].s2, got_iss[i0 + j].imm, got_iss[i0 + j].we} !==
                    {exp_iss[j].x, exp_iss[j].y, exp_iss[j].z, exp_iss[j].aluc,
                     exp_iss[j].s2, exp_iss[j].imm, exp_iss[j].we} ||
                    got_iss[i0 + j].cyc - start_cyc !== exp_iss[j].cyc) begin
                    failures++;
                    $display("FAIL rnd%0d_issue%0d got x%h y%h z%h a%h s%h I%h we%b c%0d exp x%h y%h z%h a%h s%h I%h we%b c%0d",
                             it, j, got_iss[i0 + j].x, got_iss[i0 + j].y, got_iss[i0 + j].z,
                             got_iss[i0 + j].aluc, got_iss[i0 + j].s2, got_iss[i0 + j].imm,
                             got_iss[i0 + j].we, got_iss[i0 + j].cyc - start_cyc,
                             exp_iss[j].x, exp_iss[j].y, exp_iss[j].z, exp_iss[j].aluc,
                             exp_iss[j].s2, exp_iss[j].imm, exp_iss[j].we, exp_iss[j].cyc);
                end
            end
            checks++;
            if (err !== exp_err || done !== 1'b1 || busy !== 1'b0) begin
                failures++; $display("FAIL rnd%0d_end_status got err=%b done=%b busy=%b exp err=%b done=1 busy=0",
                                     it, err, done, busy, exp_err);
            end
            checks++;
            if (done_rise.size() - d0 !== 1 || done_rise[d0] - start_cyc !== exp_done_cyc) begin
                failures++; $display("FAIL rnd%0d_done_cycle got rises=%0d exp rises=1 at %0d",
                                     it, done_rise.size() - d0, exp_done_cyc);
            end
            checks++;
            if (stall_viol - sv0 !== 0 || we_viol - wv0 !== 0) begin
                failures++; $display("FAIL rnd%0d_handshake got addr_changes=%0d we_without_en=%0d exp 0 0",
                                     it, stall_viol - sv0, we_viol - wv0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_stall();
        test_branch();
        test_halt_illegal();
        test_wrap();
        test_reset_waitp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
